mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported synchronous data/instruction memory between instruction fetch (IF)
//   and the load/store path of the memory access stage (LS).
// - Selects one requester per cycle and drives the memory port.
// - Routes the read data that returns one cycle later back to the requester that issued the read.
// - Bounds IF starvation under fixed LS priority.
// PARAMETERS
// - XLEN      32  data/address width
// - MAX_WAIT  4   max consecutive cycles IF may lose a conflict before forced IF grant
// - WAIT_W    3   width of the starvation counter; must hold MAX_WAIT
// PORTS
// - clk        in   1      clock, all state on rising edge
// - rstn       in   1      reset, asynchronous, active-low
// - i_if_req   in   1      IF read request; held with stable address until granted
// - i_if_addr  in   XLEN   IF word address
// - o_if_gnt   out  1      IF request accepted this cycle
// - o_if_rvalid out 1      IF read data valid (cycle after IF grant)
// - o_if_rdata out  XLEN   IF read data
// - i_ls_req   in   1      LS request; held with stable payload until granted
// - i_ls_we    in   1      1 = store, 0 = load
// - i_ls_addr  in   XLEN   LS address
// - i_ls_wdata in   XLEN   store data
// - i_ls_len   in   2      0 = byte, 1 = half, 2 = word
// - o_ls_gnt   out  1      LS request accepted this cycle
// - o_ls_rvalid out 1      LS load data valid (cycle after LS load grant)
// - o_ls_rdata out  XLEN   LS load data, raw; the access stage performs extension
// - o_mem_en   out  1      memory access this cycle
// - o_mem_we   out  1      memory write strobe
// - o_mem_addr out  XLEN   memory address
// - o_mem_wdata out XLEN   memory write data
// - o_mem_len  out  2      access length
// - i_mem_rdata in  XLEN   memory read data, valid the cycle after o_mem_en & !o_mem_we
// BEHAVIOUR
// - Grants are combinational from requests plus registered state. At most one grant per cycle.
// - Only one requester asserted: that requester is granted.
// - Both requesters asserted: LS is granted, unless starve_cnt == MAX_WAIT, in which case IF is granted.
//   - MAX_WAIT = 0 means IF always wins a conflict.
// - starve_cnt (WAIT_W bits, reset 0):
//   - increments when i_if_req & !o_if_gnt, saturating at MAX_WAIT
//   - clears to 0 when o_if_gnt is 1 or i_if_req is 0
// - Memory port:
//   - o_mem_en = o_if_gnt | o_ls_gnt
//   - o_mem_we = o_ls_gnt & i_ls_we
//   - o_mem_addr, o_mem_wdata, o_mem_len are muxed from the granted requester
//   - IF grant forces o_mem_len = 2 and o_mem_wdata = 0
//   - no grant: all memory outputs are 0
// - Response tracking: rsp_if and rsp_ls registers, reset 0.
//   - Next state: rsp_if <= o_if_gnt; rsp_ls <= o_ls_gnt & !i_ls_we.
//   - o_if_rvalid = rsp_if; o_ls_rvalid = rsp_ls.
//   - Stores never produce an rvalid.
// - rdata outputs:
//   - o_if_rdata = rsp_if ? i_mem_rdata : 0
//   - o_ls_rdata = rsp_ls ? i_mem_rdata : 0
// - Latency: grant in cycle N gives rvalid and data in cycle N+1. Back-to-back grants give one access per cycle.
// - Requesters must not change payload while req is high and ungranted. The arbiter does not latch payloads.
// - i_ls_len = 3 is forwarded unchanged. It is illegal upstream and is not checked here.
// - Reset asserted: all grants, o_mem_*, rvalids and rdata outputs are 0 immediately (async).
//   - starve_cnt and rsp_* clear.
//   - A read granted in the cycle reset asserts never produces rvalid.
// - Reset release: first grant is possible in the first cycle with rstn high.
// CONFIGURATION
// - MEM_ARB_RR_EN defined:
//   - conflicts resolve round-robin via a last_ls register (reset 0 = IF last); the requester
//     not granted last wins
//   - last_ls updates on every grant (1 on LS grant, 0 on IF grant)
//   - starve_cnt and MAX_WAIT are unused and are not instantiated
// - MEM_ARB_RR_EN undefined: fixed LS priority with the MAX_WAIT starvation bound described above.
// TESTING
// - IF only, addr 0x100, 3 cycles -> o_if_gnt=1 each cycle; o_if_rvalid=1 from the next cycle;
//   o_if_rdata tracks the memory model; o_ls_rvalid=0.
// - LS store, addr 0x20, wdata 0xDEADBEEF, len 2 -> o_mem_we=1, o_mem_len=2; no rvalid next cycle;
//   a later LS load of 0x20 returns 0xDEADBEEF with o_ls_rvalid=1.
// - IF and LS both held 10 cycles, MAX_WAIT=4 -> grant pattern LS,LS,LS,LS,IF repeating;
//   IF never waits more than 4 cycles.
// - Conflict with MEM_ARB_RR_EN -> strict LS,IF,LS,IF alternation starting with LS after reset.
// - Load granted, then rstn pulsed low in the next cycle -> o_ls_rvalid=0 and all o_mem_* = 0 during reset;
//   no stale rvalid after release.
// - LS byte load at 0x3 -> o_mem_len=0, o_mem_addr=0x3; o_ls_rdata is the raw memory word, one cycle later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between instruction fetch and load/store.
// Optional build macro: MEM_ARB_RR_EN selects round-robin conflict resolution instead of fixed LS priority.
module mem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [XLEN-1:0] o_if_rdata,
  input  logic            i_ls_req,
  input  logic            i_ls_we,
  input  logic [XLEN-1:0] i_ls_addr,
  input  logic [XLEN-1:0] i_ls_wdata,
  input  logic [1:0]      i_ls_len,
  output logic            o_ls_gnt,
  output logic            o_ls_rvalid,
  output logic [XLEN-1:0] o_ls_rdata,
  output logic            o_mem_en,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [1:0]      o_mem_len,
  input  logic [XLEN-1:0] i_mem_rdata
);

  logic if_gnt;
  logic ls_gnt;
  logic if_wins;
  logic rsp_if_q, rsp_if_d;
  logic rsp_ls_q, rsp_ls_d;

`ifdef MEM_ARB_RR_EN
  logic last_ls_q, last_ls_d;

  // The requester that did not win the most recent grant takes the next conflict.
  assign if_wins = last_ls_q;

  always_comb begin
    last_ls_d = last_ls_q;
    if (ls_gnt) begin
      last_ls_d = 1'b1;
    end else if (if_gnt) begin
      last_ls_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_ls_q <= 1'b0;
    end else begin
      last_ls_q <= last_ls_d;
    end
  end
`else
  logic [WAIT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign if_wins = (starve_cnt_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    starve_cnt_d = '0;
    if (i_if_req && !if_gnt) begin
      if (starve_cnt_q == WAIT_W'(MAX_WAIT)) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Grants are gated by rstn so the memory port goes quiet the moment reset asserts.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rstn) begin
      if (i_if_req && i_ls_req) begin
        if_gnt = if_wins;
        ls_gnt = !if_wins;
      end else begin
        if_gnt = i_if_req;
        ls_gnt = i_ls_req;
      end
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_len   = 2'd0;
    if (if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_if_addr;
      o_mem_len  = 2'd2;
    end else if (ls_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_len   = i_ls_len;
    end
  end

  always_comb begin
    rsp_if_d = if_gnt;
    rsp_ls_d = ls_gnt && !i_ls_we;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_if_q <= 1'b0;
      rsp_ls_q <= 1'b0;
    end else begin
      rsp_if_q <= rsp_if_d;
      rsp_ls_q <= rsp_ls_d;
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_if_rvalid = rsp_if_q;
  assign o_ls_rvalid = rsp_ls_q;
  assign o_if_rdata  = rsp_if_q ? i_mem_rdata : '0;
  assign o_ls_rdata  = rsp_ls_q ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small synchronous memory model.
// Round-robin expectations apply when MEM_ARB_RR_EN is defined.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rstn;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [1:0]  i_ls_len;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [1:0]  o_mem_len;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.XLEN(32), .MAX_WAIT(4), .WAIT_W(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_if_req   (i_if_req),
    .i_if_addr  (i_if_addr),
    .o_if_gnt   (o_if_gnt),
    .o_if_rvalid(o_if_rvalid),
    .o_if_rdata (o_if_rdata),
    .i_ls_req   (i_ls_req),
    .i_ls_we    (i_ls_we),
    .i_ls_addr  (i_ls_addr),
    .i_ls_wdata (i_ls_wdata),
    .i_ls_len   (i_ls_len),
    .o_ls_gnt   (o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid),
    .o_ls_rdata (o_ls_rdata),
    .o_mem_en   (o_mem_en),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_len  (o_mem_len),
    .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten locations read back as C0DE followed by the low address half.
  bit [31:0] mem_data [256];
  bit        mem_written [256];

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) begin
        mem_data[o_mem_addr[7:0]]    <= o_mem_wdata;
        mem_written[o_mem_addr[7:0]] <= 1'b1;
      end else begin
        i_mem_rdata <= mem_written[o_mem_addr[7:0]] ? mem_data[o_mem_addr[7:0]]
                                                    : default_word(o_mem_addr);
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a new input set just after the rising edge and leaves time for outputs to settle.
  task automatic apply_stimulus(input logic if_req, input logic [31:0] if_addr,
                                input logic ls_req, input logic ls_we,
                                input logic [31:0] ls_addr, input logic [31:0] ls_wdata,
                                input logic [1:0] ls_len);
    @(posedge clk);
    #1;
    i_if_req   = if_req;
    i_if_addr  = if_addr;
    i_ls_req   = ls_req;
    i_ls_we    = ls_we;
    i_ls_addr  = ls_addr;
    i_ls_wdata = ls_wdata;
    i_ls_len   = ls_len;
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
  endtask

  logic exp_if;
  logic prev_if;
  int   wait_run;
  int   max_wait;

  initial begin
    i_mem_rdata = 32'h0;
    rstn       = 1'b0;
    i_if_req   = 1'b1;
    i_if_addr  = 32'h100;
    i_ls_req   = 1'b1;
    i_ls_we    = 1'b0;
    i_ls_addr  = 32'h44;
    i_ls_wdata = 32'h0;
    i_ls_len   = 2'd2;
    #2;
    check_output("rst_if_gnt", o_if_gnt, 0);
    check_output("rst_ls_gnt", o_ls_gnt, 0);
    check_output("rst_mem_en", o_mem_en, 0);
    check_output("rst_mem_addr", o_mem_addr, 0);
    check_output("rst_if_rvalid", o_if_rvalid, 0);
    check_output("rst_ls_rvalid", o_ls_rvalid, 0);
    i_if_req = 1'b0;
    i_ls_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] IF-only fetch stream");
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      check_output("if_only_gnt", o_if_gnt, 1);
      check_output("if_only_ls_gnt", o_ls_gnt, 0);
      check_output("if_only_mem_addr", o_mem_addr, 32'h100);
      check_output("if_only_mem_len", o_mem_len, 2);
      check_output("if_only_mem_we", o_mem_we, 0);
      check_output("if_only_rvalid", o_if_rvalid, (k > 0) ? 1 : 0);
      if (k > 0) check_output("if_only_rdata", o_if_rdata, 32'hC0DE0100);
      check_output("if_only_ls_rvalid", o_ls_rvalid, 0);
    end
    idle();
    check_output("if_tail_rvalid", o_if_rvalid, 1);
    check_output("if_tail_rdata", o_if_rdata, 32'hC0DE0100);
    check_output("idle_mem_en", o_mem_en, 0);
    check_output("idle_mem_addr", o_mem_addr, 0);

    $display("[TB] LS store then load");
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 2'd2);
    check_output("st_ls_gnt", o_ls_gnt, 1);
    check_output("st_mem_we", o_mem_we, 1);
    check_output("st_mem_len", o_mem_len, 2);
    check_output("st_mem_wdata", o_mem_wdata, 32'hDEADBEEF);
    check_output("st_mem_addr", o_mem_addr, 32'h20);
    idle();
    check_output("st_no_rvalid", o_ls_rvalid, 0);
    check_output("st_no_rdata", o_ls_rdata, 0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd2);
    check_output("ld_ls_gnt", o_ls_gnt, 1);
    check_output("ld_mem_we", o_mem_we, 0);
    check_output("ld_mem_wdata", o_mem_wdata, 0);
    idle();
    check_output("ld_rvalid", o_ls_rvalid, 1);
    check_output("ld_rdata", o_ls_rdata, 32'hDEADBEEF);
    check_output("ld_if_rdata", o_if_rdata, 0);

    $display("[TB] LS byte load");
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3, 32'h0, 2'd0);
    check_output("byte_mem_len", o_mem_len, 0);
    check_output("byte_mem_addr", o_mem_addr, 32'h3);
    idle();
    check_output("byte_rvalid", o_ls_rvalid, 1);
    check_output("byte_rdata", o_ls_rdata, 32'hC0DE0003);

    $display("[TB] reset during outstanding load");
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 2'd2);
    check_output("rstld_ls_gnt", o_ls_gnt, 1);
    @(posedge clk);
    #1;
    i_if_req = 1'b1;
    rstn = 1'b0;
    #1;
    check_output("rstld_ls_rvalid", o_ls_rvalid, 0);
    check_output("rstld_ls_rdata", o_ls_rdata, 0);
    check_output("rstld_ls_gnt_off", o_ls_gnt, 0);
    check_output("rstld_if_gnt_off", o_if_gnt, 0);
    check_output("rstld_mem_en", o_mem_en, 0);
    check_output("rstld_mem_addr", o_mem_addr, 0);
    check_output("rstld_mem_len", o_mem_len, 0);
    @(negedge clk);
    i_if_req = 1'b0;
    i_ls_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle();
    check_output("rel_ls_rvalid", o_ls_rvalid, 0);
    check_output("rel_if_rvalid", o_if_rvalid, 0);

    $display("[TB] sustained conflict");
    prev_if  = 1'b0;
    wait_run = 0;
    max_wait = 0;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h40, 32'h0, 2'd2);
`ifdef MEM_ARB_RR_EN
      exp_if = (k % 2 == 1);
`else
      exp_if = (k % 5 == 4);
`endif
      check_output("cf_if_gnt", o_if_gnt, exp_if);
      check_output("cf_ls_gnt", o_ls_gnt, !exp_if);
      check_output("cf_mem_addr", o_mem_addr, exp_if ? 32'h104 : 32'h40);
      if (k > 0) begin
        check_output("cf_if_rvalid", o_if_rvalid, prev_if);
        check_output("cf_ls_rvalid", o_ls_rvalid, !prev_if);
        if (prev_if) check_output("cf_if_rdata", o_if_rdata, 32'hC0DE0104);
        else         check_output("cf_ls_rdata", o_ls_rdata, 32'hC0DE0040);
      end
      if (o_if_gnt) begin
        wait_run = 0;
      end else begin
        wait_run++;
        if (wait_run > max_wait) max_wait = wait_run;
      end
      prev_if = exp_if;
    end
    idle();
    check_output("cf_tail_if_rvalid", o_if_rvalid, prev_if);
    check_output("cf_tail_ls_rvalid", o_ls_rvalid, !prev_if);
`ifdef MEM_ARB_RR_EN
    check_output("cf_max_wait", max_wait, 1);
`else
    check_output("cf_max_wait", max_wait, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
